// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle EX-stage divider.
// State and handshake encodings are kept as plain 2-bit/1-bit constants for legacy RTL.
package div_pkg;

  localparam int unsigned RegBus = 32;

  typedef logic [RegBus-1:0] reg_bus_t;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef struct packed {
    reg_bus_t rem;
    reg_bus_t quot;
  } div_result_t;

  function automatic reg_bus_t cond_neg(input reg_bus_t v, input logic en);
    if (en) begin
      return (~v) + 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_if.sv
// EX <-> divider request/response bundle.
// The master side (EX) drives operands and start/annul; the divider answers with result/ready.
interface div_if;
  import div_pkg::*;

  logic        signed_div_i;
  reg_bus_t    opdata1_i;
  reg_bus_t    opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
// Bit 32 of the 33-bit difference is the borrow that decides the quotient bit.
module div_step
  import div_pkg::*;
(
  input  reg_bus_t rem_i,
  input  logic     dvd_bit_i,
  input  reg_bus_t divisor_i,
  output reg_bus_t rem_o,
  output logic     q_bit_o
);

  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  assign shifted_s = {rem_i, dvd_bit_i};
  assign diff_s    = shifted_s - {1'b0, divisor_i};

  // Restore on borrow, otherwise keep the difference.
  always_comb begin
    rem_o   = shifted_s[31:0];
    q_bit_o = 1'b0;
    if (diff_s[32] == 1'b0) begin
      rem_o   = diff_s[31:0];
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted_s[31:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned divider, one quotient bit per clock.
// Result is {remainder, quotient}; ready_o stays high while EX keeps start_i asserted.
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  logic [1:0]  state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  reg_bus_t    dividend_q, dividend_d;
  reg_bus_t    divisor_q,  divisor_d;
  reg_bus_t    rem_q,      rem_d;
  reg_bus_t    quot_q,     quot_d;
  logic        dvd_neg_q,  dvd_neg_d;
  logic        dsr_neg_q,  dsr_neg_d;
  logic        signed_q,   signed_d;
  div_result_t result_q,   result_d;
  logic        ready_q,    ready_d;

  reg_bus_t    step_rem_s;
  logic        step_q_s;
  reg_bus_t    quot_next_s;
  logic        dvd_neg_s;
  logic        dsr_neg_s;
  logic        accept_s;

  div_step u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dividend_q[31]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_q_s)
  );

  assign quot_next_s = {quot_q[30:0], step_q_s};
  assign dvd_neg_s   = bus.signed_div_i & bus.opdata1_i[31];
  assign dsr_neg_s   = bus.signed_div_i & bus.opdata2_i[31];
  assign accept_s    = (bus.start_i == DivStart) && (bus.annul_i == 1'b0);

  // Next-state and datapath control for the divide FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvd_neg_d  = dvd_neg_q;
    dsr_neg_d  = dsr_neg_q;
    signed_d   = signed_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        ready_d = DivResultNotReady;
        if (accept_s) begin
          if (bus.opdata2_i == 32'd0) begin
            state_d = DivByZero;
          end else begin
            signed_d   = bus.signed_div_i;
            dvd_neg_d  = dvd_neg_s;
            dsr_neg_d  = dsr_neg_s;
            dividend_d = cond_neg(bus.opdata1_i, dvd_neg_s);
            divisor_d  = cond_neg(bus.opdata2_i, dsr_neg_s);
            rem_d      = 32'd0;
            quot_d     = 32'd0;
            cnt_d      = 6'd0;
            state_d    = DivOn;
          end
        end else begin
          state_d = DivFree;
        end
      end

      DivByZero: begin
        result_d = '{rem: 32'd0, quot: 32'd0};
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end

      DivOn: begin
        if (bus.annul_i) begin
          ready_d = DivResultNotReady;
          cnt_d   = 6'd0;
          state_d = DivFree;
        end else begin
          rem_d      = step_rem_s;
          quot_d     = quot_next_s;
          dividend_d = {dividend_q[30:0], 1'b0};
          cnt_d      = cnt_q + 6'd1;
          // Magnitudes are unsigned; signs are restored only on the last bit.
          if (cnt_q == 6'd31) begin
            result_d.rem  = cond_neg(step_rem_s, signed_q & dvd_neg_q);
            result_d.quot = cond_neg(quot_next_s, signed_q & (dvd_neg_q ^ dsr_neg_q));
            ready_d       = DivResultReady;
            state_d       = DivEnd;
          end else begin
            state_d = DivOn;
          end
        end
      end

      DivEnd: begin
        if (bus.start_i == DivStop) begin
          result_d = '{rem: 32'd0, quot: 32'd0};
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end else begin
          state_d = DivEnd;
        end
      end

      default: begin
        result_d = '{rem: 32'd0, quot: 32'd0};
        ready_d  = DivResultNotReady;
        cnt_d    = 6'd0;
        state_d  = DivFree;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
      dvd_neg_q  <= 1'b0;
      dsr_neg_q  <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '{rem: 32'd0, quot: 32'd0};
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvd_neg_q  <= dvd_neg_d;
      dsr_neg_q  <= dsr_neg_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes reference results, a monitor pops on each ready_o rise.
// The reference uses plain 64-bit arithmetic with truncating division.
module tb_div;
  import div_pkg::*;

  logic clk;
  logic rst;
  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit scramble, input bit rst_end);
    int lat;
    logic [63:0] e;
    @(negedge clk);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    e = model(sg, a, b);
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (scramble) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!bus.ready_o && lat < 40);
    if (!bus.ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: ready_o low after %0d cycles, expected it high", lat);
      bus.start_i = 1'b0;
      return;
    end
    if (b == 32'd0) begin
      n_cmp++;
      if (!(lat inside {2, 3})) begin
        n_fail++;
        $display("FAIL zero_latency: got %0d expected 2 or 3", lat);
      end
    end else begin
      n_cmp++;
      if (lat != 33) begin
        n_fail++;
        $display("FAIL latency: got %0d expected 33", lat);
      end
    end
    for (int i = 0; i < hold; i++) begin
      bus.annul_i = (i == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      check1("hold_ready", bus.ready_o, 1'b1);
      check("hold_result", bus.result_o, e);
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    if (rst_end) rst = 1'b0;
    @(negedge clk);
    check1("drop_ready", bus.ready_o, 1'b0);
    check("drop_result", bus.result_o, 64'd0);
    rst = 1'b1;
  endtask

  task automatic abort_test(input int at, input bit use_rst);
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (at) @(negedge clk);
    bus.start_i = 1'b0;
    if (use_rst) rst = 1'b0;
    else bus.annul_i = 1'b1;
    @(negedge clk);
    check1("abort_ready", bus.ready_o, 1'b0);
    check("abort_result", bus.result_o, 64'd0);
    rst = 1'b1;
    bus.annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check1("abort_quiet", bus.ready_o, 1'b0);
  endtask

  // Monitor: every rising ready_o consumes one expected result.
  initial begin : monitor
    logic prev;
    logic [63:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready_o && !prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: result %h with no request outstanding", bus.result_o);
        end else begin
          e = exp_q.pop_front();
          check("result", bus.result_o, e);
        end
      end
      prev = bus.ready_o;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a, b;
    logic        sg;
    int          r;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_ready", bus.ready_o, 1'b0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check1("idle_ready", bus.ready_o, 1'b0);

    run_div(1'b0, 32'd100, 32'd7, 0, 1'b0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 2, 1'b0, 1'b0);
    abort_test(10, 1'b0);
    abort_test(10, 1'b1);
    run_div(1'b0, 32'd9, 32'd3, 0, 1'b0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, 1'b0, 1'b0);
    run_div(1'b0, 32'hDEAD_BEEF, 32'd1234, 0, 1'b1, 1'b0);
    run_div(1'b1, 32'h8765_4321, 32'h0000_0fed, 0, 1'b1, 1'b0);
    run_div(1'b0, 32'd1000, 32'd3, 2, 1'b0, 1'b1);

    // start together with annul must be ignored in the idle state
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check1("start_annul_ignored", bus.ready_o, 1'b0);

    for (int n = 0; n < 20; n++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r < 4) b = 32'($urandom_range(1, 17));
      else if (r == 4) b = 32'hFFFF_FFFF;
      else b = $urandom;
      run_div(sg, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
